// File: rtl/ujtag_dr_bank_pkg.sv
// Shared definitions for the UJTAG user DR bank and its JTAG driver.
// Holds the IR codes, the DR select encoding, the DR length table and the IR decoder.
// No ports; pure declarations.
package ujtag_pkg;

  localparam logic [7:0] IR_ID     = 8'h10;
  localparam logic [7:0] IR_CTRL   = 8'h11;
  localparam logic [7:0] IR_STATUS = 8'h12;
  localparam logic [7:0] IR_COUNT  = 8'h13;

  typedef enum logic [2:0] {
    SEL_BYPASS,
    SEL_ID,
    SEL_CTRL,
    SEL_STATUS,
    SEL_COUNT
  } dr_sel_t;

  // Shift length of each DR; 6 bits so that 32 is representable.
  function automatic logic [5:0] dr_len(dr_sel_t sel);
    case (sel)
      SEL_ID:     dr_len = 6'd32;
      SEL_CTRL:   dr_len = 6'd16;
      SEL_STATUS: dr_len = 6'd16;
      SEL_COUNT:  dr_len = 6'd16;
      default:    dr_len = 6'd1;
    endcase
  endfunction

  // Unknown codes fall through to BYPASS.
  function automatic dr_sel_t ir_decode(logic [7:0] ir);
    case (ir)
      IR_ID:     ir_decode = SEL_ID;
      IR_CTRL:   ir_decode = SEL_CTRL;
      IR_STATUS: ir_decode = SEL_STATUS;
      IR_COUNT:  ir_decode = SEL_COUNT;
      default:   ir_decode = SEL_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/ujtag_dr_shift.sv
// Variable-length capture/shift register with registered serial output.
// Latency: capture value / shifted bit visible on tdo from the loading edge; no backpressure.
// Ports: clk, rst (sync, active-high), cap/sh strobes, len (1..32), cap_val, tdi in;
//        tdo (mirrors sr[0]) and par (low 16 bits of sr, the update payload) out.
module ujtag_dr_shift (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic        sh,
  input  logic [5:0]  len,
  input  logic [31:0] cap_val,
  input  logic        tdi,
  output logic        tdo,
  output logic [15:0] par
);

  logic [31:0] sr;
  logic [31:0] mask;
  logic [31:0] shifted;

  // mask covers bits [len-1:0]; the shifted-down part is limited to [len-2:0]
  // and tdi lands at len-1, so everything at or above len stays zero.
  always_comb begin
    mask    = 32'hFFFF_FFFF >> (6'd32 - len);
    shifted = ({1'b0, sr[31:1]} & (mask >> 1)) | ({31'b0, tdi} << (len - 6'd1));
  end

  // tdo is loaded with the same value as sr[0] so it is a flop, never a
  // combinational path from tdi.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      tdo <= 1'b0;
    end else if (cap) begin
      sr  <= cap_val;
      tdo <= cap_val[0];
    end else if (sh) begin
      sr  <= shifted;
      tdo <= shifted[0];
    end
  end

  assign par = sr[15:0];

endmodule

// File: rtl/ujtag_dr_bank.sv
// User DR bank behind UJTAG: ID, CTRL (r/w), STATUS and update-count registers.
// Latency: CTRL and CTRL_UPD change on the edge where UDRUPD is first seen high; no backpressure.
// Ports: UDRCK/URST clock and sync reset; UIREG, UDRCAP, UDRSH, UDRUPD, UTDI from UJTAG;
//        UTDO back to UJTAG; STATUS sampled at capture; CTRL word and CTRL_UPD pulse out.
module ujtag_dr_bank
  import ujtag_pkg::*;
#(
  parameter logic [31:0] USERCODE = 32'h4D43_4A01,
  parameter logic [15:0] CTRL_RST = 16'h0000
) (
  input  logic        UDRCK,
  input  logic        URST,
  input  logic [7:0]  UIREG,
  input  logic        UDRCAP,
  input  logic        UDRSH,
  input  logic        UDRUPD,
  input  logic        UTDI,
  output logic        UTDO,
  input  logic [15:0] STATUS,
  output logic [15:0] CTRL,
  output logic        CTRL_UPD
);

  dr_sel_t     sel_q;
  dr_sel_t     cap_sel;
  logic        upd_q;
  logic [15:0] upd_cnt;
  logic [31:0] cap_val;
  logic [15:0] par;
  logic        upd_fire;

  assign cap_sel = ir_decode(UIREG);

  always_comb begin
    cap_val = '0;
    case (cap_sel)
      SEL_ID:     cap_val = USERCODE;
      SEL_CTRL:   cap_val = {16'h0, CTRL};
      SEL_STATUS: cap_val = {16'h0, STATUS};
      SEL_COUNT:  cap_val = {16'h0, upd_cnt};
      default:    cap_val = '0;
    endcase
  end

  // Shift length follows the latched select, so UIREG may move after capture.
  ujtag_dr_shift u_shift (
    .clk     (UDRCK),
    .rst     (URST),
    .cap     (UDRCAP),
    .sh      (UDRSH),
    .len     (dr_len(sel_q)),
    .cap_val (cap_val),
    .tdi     (UTDI),
    .tdo     (UTDO),
    .par     (par)
  );

  // Capture and shift outrank update on the same edge; upd_q still tracks
  // UDRUPD so a suppressed rising edge is not replayed later.
  assign upd_fire = UDRUPD && !upd_q && !UDRCAP && !UDRSH && (sel_q == SEL_CTRL);

  always_ff @(posedge UDRCK) begin
    if (URST) begin
      sel_q    <= SEL_BYPASS;
      upd_q    <= 1'b0;
      CTRL     <= CTRL_RST;
      CTRL_UPD <= 1'b0;
      upd_cnt  <= '0;
    end else begin
      upd_q    <= UDRUPD;
      CTRL_UPD <= 1'b0;
      if (UDRCAP) begin
        sel_q <= cap_sel;
      end else if (upd_fire) begin
        CTRL     <= par;
        CTRL_UPD <= 1'b1;
        upd_cnt  <= upd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ujtag_dr_bank.sv
// Directed bench for ujtag_dr_bank: drives capture/shift/update sequences
// the way the UJTAG would and checks serial output, CTRL and the update counter.
module tb_ujtag_dr_bank;
  import ujtag_pkg::*;

  logic        UDRCK = 1'b0;
  logic        URST = 1'b1;
  logic [7:0]  UIREG = 8'h00;
  logic        UDRCAP = 1'b0;
  logic        UDRSH = 1'b0;
  logic        UDRUPD = 1'b0;
  logic        UTDI = 1'b0;
  logic        UTDO;
  logic [15:0] STATUS = 16'hBEEF;
  logic [15:0] CTRL;
  logic        CTRL_UPD;

  int checks = 0;
  int failures = 0;

  ujtag_dr_bank dut (
    .UDRCK    (UDRCK),
    .URST     (URST),
    .UIREG    (UIREG),
    .UDRCAP   (UDRCAP),
    .UDRSH    (UDRSH),
    .UDRUPD   (UDRUPD),
    .UTDI     (UTDI),
    .UTDO     (UTDO),
    .STATUS   (STATUS),
    .CTRL     (CTRL),
    .CTRL_UPD (CTRL_UPD)
  );

  always #5 UDRCK = ~UDRCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge UDRCK);
    #1;
  endtask

  task automatic capture(input logic [7:0] ir);
    UIREG  = ir;
    UDRCAP = 1'b1;
    tick();
    UDRCAP = 1'b0;
  endtask

  // UTDO is sampled before each shift edge, so dout collects bits LSB-first.
  task automatic shift(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout  = '0;
    UDRSH = 1'b1;
    for (int i = 0; i < n; i++) begin
      dout[i] = UTDO;
      UTDI    = din[i];
      tick();
    end
    UDRSH = 1'b0;
    UTDI  = 1'b0;
  endtask

  // p1: CTRL_UPD in the cycle after the rising UDRUPD edge; p2: one cycle later.
  task automatic update(output logic p1, output logic p2);
    UDRUPD = 1'b1;
    tick();
    p1 = CTRL_UPD;
    UDRUPD = 1'b0;
    tick();
    p2 = CTRL_UPD;
  endtask

  task automatic read_dr(input logic [7:0] ir, input int n, output logic [31:0] dout);
    capture(ir);
    shift(n, 32'h0, dout);
  endtask

  initial begin
    logic [31:0] d;
    logic        p1, p2;
    int          pulses;

    // 1. Reset
    URST = 1'b1;
    tick();
    tick();
    URST = 1'b0;
    chk("rst_utdo", {31'b0, UTDO}, 32'h0);
    chk("rst_ctrl", {16'b0, CTRL}, 32'h0);
    chk("rst_ctrl_upd", {31'b0, CTRL_UPD}, 32'h0);
    read_dr(IR_COUNT, int'(dr_len(SEL_COUNT)), d);
    chk("rst_count", d, 32'h0);

    // 2. ID read
    read_dr(IR_ID, int'(dr_len(SEL_ID)), d);
    chk("id_read", d, 32'h4D43_4A01);

    // STATUS read
    read_dr(IR_STATUS, int'(dr_len(SEL_STATUS)), d);
    chk("status_read", d, 32'h0000_BEEF);

    // 3. CTRL write then readback while writing 0x0001
    capture(IR_CTRL);
    shift(16, 32'h0000_A5C3, d);
    chk("ctrl_first_out", d, 32'h0);
    update(p1, p2);
    chk("ctrl_upd_pulse", {31'b0, p1}, 32'h1);
    chk("ctrl_upd_drop", {31'b0, p2}, 32'h0);
    chk("ctrl_a5c3", {16'b0, CTRL}, 32'h0000_A5C3);
    capture(IR_CTRL);
    UIREG = 8'h7F;  // must be ignored until the next capture
    shift(16, 32'h0000_0001, d);
    chk("ctrl_readback", d, 32'h0000_A5C3);
    update(p1, p2);
    chk("ctrl_0001", {16'b0, CTRL}, 32'h0000_0001);
    read_dr(IR_COUNT, 16, d);
    chk("count_2", d, 32'h2);

    // 4. UDRUPD held for 4 edges yields one update
    capture(IR_CTRL);
    shift(16, 32'h0000_1234, d);
    pulses = 0;
    UDRUPD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (CTRL_UPD) pulses++;
    end
    UDRUPD = 1'b0;
    tick();
    if (CTRL_UPD) pulses++;
    chk("held_upd_pulses", pulses, 1);
    chk("held_upd_ctrl", {16'b0, CTRL}, 32'h0000_1234);
    read_dr(IR_COUNT, 16, d);
    chk("count_3", d, 32'h3);

    // 5. Counter wrap: 3 + 65532 = 0xFFFF, then one more wraps to 0
    capture(IR_CTRL);
    for (int k = 0; k < 65532; k++) begin
      UDRUPD = 1'b1;
      tick();
      UDRUPD = 1'b0;
      tick();
    end
    read_dr(IR_COUNT, 16, d);
    chk("count_ffff", d, 32'h0000_FFFF);
    capture(IR_CTRL);
    update(p1, p2);
    chk("wrap_pulse", {31'b0, p1}, 32'h1);
    read_dr(IR_COUNT, 16, d);
    chk("count_wrap", d, 32'h0);
    chk("wrap_ctrl", {16'b0, CTRL}, 32'h0000_1234);

    // 6a. Bypass: UTDI 1,0,1,1 -> UTDO 0,1,0,1 seen before each edge
    capture(8'h7F);
    shift(4, 32'h0000_000D, d);
    chk("bypass_out", d, 32'h0000_000A);
    chk("bypass_last", {31'b0, UTDO}, 32'h1);

    // 6b. Reset after 8 of 16 CTRL shifts; the following update is a no-op
    capture(IR_CTRL);
    shift(8, 32'h0000_00FF, d);
    URST = 1'b1;
    tick();
    URST = 1'b0;
    chk("midrst_utdo", {31'b0, UTDO}, 32'h0);
    chk("midrst_ctrl", {16'b0, CTRL}, 32'h0);
    update(p1, p2);
    chk("midrst_no_pulse", {31'b0, p1}, 32'h0);
    chk("midrst_ctrl_after_upd", {16'b0, CTRL}, 32'h0);
    read_dr(IR_COUNT, 16, d);
    chk("midrst_count", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
